// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   ADDSUB_OP_ADD / ADDSUB_OP_SUB : encodings of the 'sub' control input
//   ADDSUB_DEFAULT_WIDTH/STAGES   : default operand width and pipeline depth
//   full_add                      : one-bit full-adder cell used by every chunk
package pipelined_addsub_pkg;

    localparam logic ADDSUB_OP_ADD = 1'b0;
    localparam logic ADDSUB_OP_SUB = 1'b1;

    localparam int ADDSUB_DEFAULT_WIDTH  = 32;
    localparam int ADDSUB_DEFAULT_STAGES = 4;

    typedef struct packed {
        logic cout;
        logic s;
    } fa_out_t;

    function automatic fa_out_t full_add(input logic x, input logic y, input logic cin);
        fa_out_t r;
        r.s    = x ^ y ^ cin;
        r.cout = (x & y) | (cin & (x ^ y));
        return r;
    endfunction

endpackage

// File: rtl/pipelined_addsub_stage.sv
// One carry-chain chunk of the pipelined adder/subtractor plus its pipeline
// register and handshake logic.
//   clk, rst_n      : clock, synchronous active-low reset (valid bit always;
//                     result registers only when RST_DATA=1)
//   v_up            : upstream stage holds a valid op
//   adv_dn          : downstream stage can accept this cycle
//   adv             : this stage can accept this cycle (loads when v_up)
//   v               : this stage holds a valid op
//   a_in/b_in       : operands from upstream (b already inverted for subtract)
//   sum_in          : sum bits completed by earlier stages
//   cin             : carry into this chunk
//   a_out/b_out     : registered operands passed downstream
//   sum_out         : registered sum with this chunk's bits filled in
//   cout            : registered carry out of this chunk
//   cmsb            : registered carry into this chunk's MSB
//   load            : this stage captures a new op at the coming edge
//   sum_nxt         : combinational sum that will be captured on load
module pipelined_addsub_stage
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH    = ADDSUB_DEFAULT_WIDTH,
    parameter int CHUNK    = ADDSUB_DEFAULT_WIDTH / ADDSUB_DEFAULT_STAGES,
    parameter int IDX      = 0,
    parameter bit RST_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             v_up,
    input  logic             adv_dn,
    output logic             adv,
    output logic             v,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cin,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             cmsb,
    output logic             load,
    output logic [WIDTH-1:0] sum_nxt
);

    localparam int LO = IDX * CHUNK;

    logic             v_q, v_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             cmsb_q, cmsb_d;

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] s;

    // Ripple carry across this chunk only; the chain is cut at the register.
    always_comb begin
        fa_out_t fa;
        c    = '0;
        s    = '0;
        fa   = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            fa     = full_add(a_in[LO+i], b_in[LO+i], c[i]);
            s[i]   = fa.s;
            c[i+1] = fa.cout;
        end
    end

    always_comb begin
        sum_nxt            = sum_in;
        sum_nxt[LO +: CHUNK] = s;
    end

    // Bubble-collapsing handshake: an empty stage always accepts, a full one
    // accepts only if it can pass its op on at the same edge.
    always_comb begin
        adv    = ~v_q | adv_dn;
        load   = adv & v_up;
        v_d    = adv ? v_up : v_q;
        a_d    = load ? a_in     : a_q;
        b_d    = load ? b_in     : b_q;
        sum_d  = load ? sum_nxt  : sum_q;
        cout_d = load ? c[CHUNK] : cout_q;
        cmsb_d = load ? c[CHUNK-1] : cmsb_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // Only the stage driving the block outputs clears its result fields.
    generate
        if (RST_DATA) begin : g_rst_data
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    cmsb_q <= 1'b0;
                end else begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                    cmsb_q <= cmsb_d;
                end
            end
        end else begin : g_no_rst_data
            always_ff @(posedge clk) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                cmsb_q <= cmsb_d;
            end
        end
    endgenerate

    assign v       = v_q;
    assign a_out   = a_q;
    assign b_out   = b_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;
    assign cmsb    = cmsb_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake.
// The carry chain is split into STAGES chunks of WIDTH/STAGES bits, with the
// carry registered between chunks.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operation handshake (a, b, sub)
//   a, b                : operands
//   sub                 : 0 = a+b, 1 = a-b
//   out_valid/out_ready : result handshake
//   sum                 : result modulo 2^WIDTH
//   carry               : carry out of MSB (subtract: 1 = no borrow)
//   overflow            : signed overflow
//   zero                : sum == 0
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = ADDSUB_DEFAULT_WIDTH,
    parameter int STAGES = ADDSUB_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    generate
        if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
            $fatal(1, "pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
        end
    endgenerate

    // Index k of each array is the input side of stage k; index k+1 its output.
    logic             v_w       [STAGES+1];
    logic             adv_w     [STAGES+1];
    logic [WIDTH-1:0] a_w       [STAGES+1];
    logic [WIDTH-1:0] b_w       [STAGES+1];
    logic [WIDTH-1:0] sum_w     [STAGES+1];
    logic             cout_w    [STAGES+1];
    logic             cmsb_w    [STAGES];
    logic             load_w    [STAGES];
    logic [WIDTH-1:0] sum_nxt_w [STAGES];

    logic zero_q, zero_d;

    // Subtraction is A + ~B + 1: B is inverted once here and the +1 enters as
    // the carry into stage 0.
    assign v_w[0]      = in_valid;
    assign adv_w[STAGES] = out_ready;
    assign a_w[0]      = a;
    assign b_w[0]      = (sub == ADDSUB_OP_SUB) ? ~b : b;
    assign sum_w[0]    = '0;
    assign cout_w[0]   = sub;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            pipelined_addsub_stage #(
                .WIDTH    (WIDTH),
                .CHUNK    (CHUNK),
                .IDX      (k),
                .RST_DATA (k == STAGES - 1)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .v_up    (v_w[k]),
                .adv_dn  (adv_w[k+1]),
                .adv     (adv_w[k]),
                .v       (v_w[k+1]),
                .a_in    (a_w[k]),
                .b_in    (b_w[k]),
                .sum_in  (sum_w[k]),
                .cin     (cout_w[k]),
                .a_out   (a_w[k+1]),
                .b_out   (b_w[k+1]),
                .sum_out (sum_w[k+1]),
                .cout    (cout_w[k+1]),
                .cmsb    (cmsb_w[k]),
                .load    (load_w[k]),
                .sum_nxt (sum_nxt_w[k])
            );
        end
    endgenerate

    // The zero flag is evaluated on the complete sum as it enters the last
    // register, so it needs no wide compare after the output flops.
    always_comb begin
        zero_d = zero_q;
        if (load_w[STAGES-1]) begin
            zero_d = (sum_nxt_w[STAGES-1] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign in_ready  = adv_w[0];
    assign out_valid = v_w[STAGES];
    assign sum       = sum_w[STAGES];
    assign carry     = cout_w[STAGES];
    assign overflow  = cout_w[STAGES] ^ cmsb_w[STAGES-1];
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, iv_x;
    logic         out_ready, or_x;
    logic [W-1:0] a, b;
    logic         sub;

    logic         in_ready4, out_valid4, carry4, ovf4, zero4;
    logic [W-1:0] sum4;
    logic         in_ready1, out_valid1, carry1, ovf1, zero1;
    logic [W-1:0] sum1;
    logic         in_ready32, out_valid32, carry32, ovf32, zero32;
    logic [W-1:0] sum32;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [34:0] expq[$];
    logic [31:0] bp_a [6];
    logic [31:0] bp_b [6];
    logic        bp_s [6];

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .carry(carry4), .overflow(ovf4), .zero(zero4)
    );

    pipelined_addsub #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(in_ready1),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(or_x),
        .sum(sum1), .carry(carry1), .overflow(ovf1), .zero(zero1)
    );

    pipelined_addsub #(.WIDTH(W), .STAGES(32)) dut_s32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(in_ready32),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid32), .out_ready(or_x),
        .sum(sum32), .carry(carry32), .overflow(ovf32), .zero(zero32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: wide add, overflow from operand/result sign bits.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] yy;
        logic [32:0] r;
        logic        v;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {32'b0, s};
        v  = (x[31] == yy[31]) && (r[31] != x[31]);
        return {r[32], v, (r[31:0] == 32'd0), r[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op into all three widths; expected = {carry, overflow, zero, sum}.
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic vs, input logic [34:0] exp);
        int          lat4 = 0, lat1 = 0, lat32 = 0;
        logic [34:0] r4 = '0, r1 = '0, r32 = '0;
        a = va; b = vb; sub = vs;
        in_valid = 1'b1; iv_x = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (cyc == 1) begin
                in_valid = 1'b0; iv_x = 1'b0;
            end
            if (out_valid4 && lat4 == 0) begin
                lat4 = cyc; r4 = {carry4, ovf4, zero4, sum4};
            end
            if (out_valid1 && lat1 == 0) begin
                lat1 = cyc; r1 = {carry1, ovf1, zero1, sum1};
            end
            if (out_valid32 && lat32 == 0) begin
                lat32 = cyc; r32 = {carry32, ovf32, zero32, sum32};
            end
        end
        chk({tag, " s4 result"}, r4, exp);
        chk({tag, " s4 latency"}, lat4, 4);
        chk({tag, " s1 result"}, r1, exp);
        chk({tag, " s1 latency"}, lat1, 1);
        chk({tag, " s32 result"}, r32, exp);
        chk({tag, " s32 latency"}, lat32, 32);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          ptr, got, first_out, last_out, drops, seen;
        logic [34:0] snap, head;

        rst_n = 1'b0; in_valid = 1'b0; iv_x = 1'b0;
        out_ready = 1'b1; or_x = 1'b1;
        a = '0; b = '0; sub = 1'b0;
        bp_a = '{32'd10, 32'd100, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd1};
        bp_b = '{32'd20, 32'd1,   32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd2};
        bp_s = '{1'b0,   1'b1,    1'b0,          1'b1,  1'b0,          1'b1};

        tick(); tick();
        chk("reset out_valid", out_valid4, 0);
        chk("reset in_ready", in_ready4, 1);
        chk("reset flags+sum", {carry4, ovf4, zero4, sum4}, 0);
        chk("reset s1/s32 out_valid", {out_valid1, out_valid32}, 0);
        rst_n = 1'b1;
        tick();

        // Directed vectors: {carry, overflow, zero, sum}
        run_vec("1+1",          32'h0000_0001, 32'h0000_0001, 1'b0, {3'b000, 32'h0000_0002});
        run_vec("FFFFFFFF+1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {3'b101, 32'h0000_0000});
        run_vec("7FFFFFFF+1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {3'b010, 32'h8000_0000});
        run_vec("5-7",          32'h0000_0005, 32'h0000_0007, 1'b1, {3'b000, 32'hFFFF_FFFE});
        run_vec("80000000-1",   32'h8000_0000, 32'h0000_0001, 1'b1, {3'b110, 32'h7FFF_FFFF});

        // Back-to-back random stream
        expq.delete();
        got = 0; first_out = -1; last_out = -1; drops = 0;
        for (int cyc = 0; cyc < 130; cyc++) begin
            if (cyc < 100) begin
                a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid4) begin
                if (expq.size() == 0) begin
                    chk("stream unexpected result", out_valid4, 0);
                end else begin
                    head = expq.pop_front();
                    chk("stream result", {carry4, ovf4, zero4, sum4}, head);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
            if (in_valid) begin
                if (in_ready4) expq.push_back(model(a, b, sub));
                else drops++;
            end
            tick();
        end
        chk("stream count", got, 100);
        chk("stream first latency", first_out, 4);
        chk("stream one per cycle", last_out - first_out + 1, 100);
        chk("stream in_ready drops", drops, 0);

        // Backpressure
        expq.delete();
        out_ready = 1'b0;
        ptr = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = (ptr < 6);
            if (ptr < 6) begin
                a = bp_a[ptr]; b = bp_b[ptr]; sub = bp_s[ptr];
            end
            @(negedge clk);
            if (in_valid && in_ready4) begin
                expq.push_back(model(bp_a[ptr], bp_b[ptr], bp_s[ptr]));
                ptr++;
            end
            tick();
        end
        chk("bp accepted while stalled", ptr, 4);
        chk("bp in_ready low", in_ready4, 0);
        chk("bp out_valid high", out_valid4, 1);
        snap = {carry4, ovf4, zero4, sum4};
        chk("bp head on outputs", snap, {3'b000, 32'd30});
        tick(); tick(); tick();
        chk("bp outputs stable", {carry4, ovf4, zero4, sum4}, snap);
        chk("bp still stalled", {in_ready4, out_valid4}, 2'b01);
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
            in_valid = (ptr < 6);
            if (ptr < 6) begin
                a = bp_a[ptr]; b = bp_b[ptr]; sub = bp_s[ptr];
            end
            @(negedge clk);
            if (out_valid4) begin
                if (expq.size() == 0) begin
                    chk("bp unexpected result", out_valid4, 0);
                end else begin
                    head = expq.pop_front();
                    chk("bp result", {carry4, ovf4, zero4, sum4}, head);
                end
                got++;
            end
            if (in_valid && in_ready4) begin
                expq.push_back(model(bp_a[ptr], bp_b[ptr], bp_s[ptr]));
                ptr++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("bp results drained", got, 6);
        chk("bp all ops accepted", ptr, 6);

        // Reset with 3 ops in flight
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            a = 32'd1000 + 32'(i); b = 32'd1; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midreset out_valid", out_valid4, 0);
        chk("midreset in_ready", in_ready4, 1);
        chk("midreset outputs cleared", {carry4, ovf4, zero4, sum4}, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (out_valid4) seen++;
        end
        chk("midreset no stale results", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
